// File: rtl/cyclic_code_pkg.sv
// Shared code definition for the serial cyclic coder and decoder:
// code dimensions, generator polynomial and the per-bit syndrome step.
package cyclic_code_pkg;

  localparam int N  = 15;
  localparam int K  = 11;
  localparam int R  = N - K;
  localparam int CW = $clog2(N + 1);

  // Bit i is the coefficient of x^i; GEN[R] and GEN[0] must be 1.
  localparam logic [R:0] GEN = 5'b10011;

  // Returns ((s<<1)|b) mod GEN, R bits wide.
  function automatic logic [R-1:0] poly_step(input logic [R-1:0] s, input logic b);
    logic [R:0] t;
    t = {s, b};
    if (t[R]) t = t ^ GEN;
    return t[R-1:0];
  endfunction

  // x^(N-1) mod GEN: the syndrome left by a single error in the top bit.
  function automatic logic [R-1:0] calc_pat();
    logic [R-1:0] s;
    s    = '0;
    s[0] = 1'b1;
    for (int i = 0; i < N - 1; i++) s = poly_step(s, 1'b0);
    return s;
  endfunction

  localparam logic [R-1:0] PAT = calc_pat();

endpackage

// File: rtl/cyclic_syndrome_reg.sv
// R-bit syndrome register: clear, parallel load, shift with an input bit,
// or shift with zero input. Priority follows that order.
module cyclic_syndrome_reg
  import cyclic_code_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [R-1:0] i_load_val,
  input  logic         i_shift_in,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [R-1:0] o_syn
);

  logic [R-1:0] r_syn;

  // Syndrome update, one mode per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_syn <= '0;
    else if (i_clear)    r_syn <= '0;
    else if (i_load)     r_syn <= i_load_val;
    else if (i_shift_in) r_syn <= poly_step(r_syn, i_bit);
    else if (i_shift)    r_syn <= poly_step(r_syn, 1'b0);
  end

  assign o_syn = r_syn;

endmodule

// File: rtl/cyclic_decoder_systematic.sv
// Serial Meggitt decoder for a systematic cyclic code. Receive stage
// builds the syndrome and buffers the message bits; on the last codeword
// bit both are handed to the output stage, which streams the K message
// bits out while rotating its syndrome copy to locate and flip one error.
module cyclic_decoder_systematic
  import cyclic_code_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_sof,
  input  logic in_bit,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic out_bit,
  output logic out_err,
  output logic out_corr
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // receive stage
  logic          r_open;
  logic [CW-1:0] r_cnt;
  logic [K-1:0]  r_msg;
  logic [R-1:0]  w_rx_syn;
  logic [R-1:0]  w_rx_base;
  logic [R-1:0]  w_rx_step;
  logic [CW-1:0] w_cnt_base;
  logic [K-1:0]  w_msg_base;
  logic          w_acc;
  logic          w_last;
  logic          w_handoff;

  // output stage
  state_t        r_state, w_state_nxt;
  logic [K-1:0]  r_obuf;
  logic [CW-1:0] r_step;
  logic          r_err;
  logic          r_corr;
  logic [R-1:0]  w_tx_syn;
  logic          w_shifting;
  logic          w_match;
  logic          w_step_last;

  // A start-of-frame bit restarts from an empty syndrome and count.
  assign w_acc      = in_valid && (in_sof || r_open);
  assign w_cnt_base = in_sof ? '0 : r_cnt;
  assign w_rx_base  = in_sof ? '0 : w_rx_syn;
  assign w_msg_base = in_sof ? '0 : r_msg;
  assign w_rx_step  = poly_step(w_rx_base, in_bit);
  assign w_last     = (w_cnt_base == CW'(N - 1));
  assign w_handoff  = w_acc && w_last;

  cyclic_syndrome_reg u_rx_syn (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_handoff),
    .i_load     (w_acc && in_sof),
    .i_load_val (w_rx_step),
    .i_shift_in (w_acc && !in_sof),
    .i_shift    (1'b0),
    .i_bit      (in_bit),
    .o_syn      (w_rx_syn)
  );

  // Bit counter and message buffer for the frame being received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= 1'b0;
      r_cnt  <= '0;
      r_msg  <= '0;
    end else if (w_acc) begin
      if (w_cnt_base < CW'(K)) r_msg <= {w_msg_base[K-2:0], in_bit};
      if (w_last) begin
        r_open <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_open <= 1'b1;
        r_cnt  <= w_cnt_base + 1'b1;
      end
    end
  end

  assign w_shifting  = (r_state == S_SHIFT);
  assign w_match     = w_shifting && (w_tx_syn == PAT);
  assign w_step_last = (r_step == CW'(K - 1));

  // A handoff reload wins over the correction clear of the outgoing frame.
  cyclic_syndrome_reg u_tx_syn (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_match && !w_handoff),
    .i_load     (w_handoff),
    .i_load_val (w_rx_step),
    .i_shift_in (1'b0),
    .i_shift    (w_shifting),
    .i_bit      (1'b0),
    .o_syn      (w_tx_syn)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a handoff always (re)starts SHIFT, otherwise run K steps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_handoff) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_step_last && !w_handoff) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output buffer, step counter and per-frame error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obuf <= '0;
      r_step <= '0;
      r_err  <= 1'b0;
      r_corr <= 1'b0;
    end else if (w_handoff) begin
      r_obuf <= r_msg;
      r_step <= '0;
      r_err  <= |w_rx_step;
      r_corr <= 1'b0;
    end else if (w_shifting) begin
      r_obuf <= {r_obuf[K-2:0], 1'b0};
      r_step <= r_step + 1'b1;
      if (w_match) r_corr <= 1'b1;
    end
  end

  assign out_valid = w_shifting;
  assign out_sof   = w_shifting && (r_step == '0);
  assign out_eof   = w_shifting && w_step_last;
  assign out_bit   = w_shifting && (r_obuf[K-1] ^ w_match);
  assign out_err   = w_shifting && r_err;
  assign out_corr  = w_shifting && (r_corr || w_match);

endmodule

// File: tb/tb_cyclic_decoder_systematic.sv
// Scoreboard bench for cyclic_decoder_systematic: stimulus pushes the
// expected message bits per frame, a negedge monitor pops and compares.
module tb_cyclic_decoder_systematic;
  import cyclic_code_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_bit = 1'b0;
  logic out_valid, out_sof, out_eof, out_bit, out_err, out_corr;

  cyclic_decoder_systematic dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_bit(out_bit),
    .out_err(out_err), .out_corr(out_corr)
  );

  always #5 clk = ~clk;

  typedef struct {logic b; logic sof; logic eof; logic err; logic corr;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // GF(2) polynomial remainder of v (nbits wide) by GEN.
  function automatic int gf_mod(input int v, input int nbits);
    int r;
    r = v;
    for (int i = nbits - 1; i >= R; i--)
      if (r[i]) r = r ^ (int'(GEN) << (i - R));
    return r & ((1 << R) - 1);
  endfunction

  function automatic int encode(input int msg);
    return (msg << R) | gf_mod(msg << R, N);
  endfunction

  // Single-error decoding: the syndrome names the error position.
  task automatic model_decode(input int cw, output int msg, output bit err, output bit corr);
    int s;
    s    = gf_mod(cw, N);
    msg  = cw >> R;
    err  = (s != 0);
    corr = 1'b0;
    if (s != 0)
      for (int e = R; e < N; e++)
        if (gf_mod(1 << e, N) == s) begin
          msg  = msg ^ (1 << (e - R));
          corr = 1'b1;
        end
  endtask

  task automatic push_frame(input int msg, input bit err, input bit corr);
    exp_t e;
    for (int j = 0; j < K; j++) begin
      e.b = msg[K-1-j]; e.sof = (j == 0); e.eof = (j == K - 1);
      e.err = err; e.corr = corr;
      sb.push_back(e);
    end
  endtask

  task automatic send_bits(input logic [N-1:0] cw, input int nbits, input int gap_max);
    for (int i = N - 1; i >= N - nbits; i--) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin in_valid = 1'b0; in_sof = 1'b0; @(posedge clk); #1; end
      end
      in_valid = 1'b1; in_sof = (i == N - 1); in_bit = cw[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Full frame; first out_valid must be visible right after the last bit's edge.
  task automatic send_frame(input logic [N-1:0] cw, input int gap_max);
    send_bits(cw, N, gap_max);
    check1("latency_valid", out_valid, 1);
    check1("latency_sof", out_sof, 1);
  endtask

  task automatic send_model(input logic [N-1:0] cw, input int gap_max);
    int m; bit e; bit c;
    model_decode(int'(cw), m, e, c);
    push_frame(m, e, c);
    send_frame(cw, gap_max);
  endtask

  task automatic random_frame(input int max_err, input int gap_max);
    int msg; int ne; logic [N-1:0] cw;
    msg = $urandom_range((1 << K) - 1, 0);
    cw  = N'(encode(msg));
    ne  = $urandom_range(max_err, 0);
    for (int i = 0; i < ne; i++) cw[$urandom_range(N - 1, 0)] ^= 1'b1;
    send_model(cw, gap_max);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected bits never produced", sb.size());
    end
  endtask

  // Monitor: compare every presented output bit against the scoreboard.
  initial begin
    exp_t e;
    bit in_frame;
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: out_valid=1 with nothing expected at %0t", $time);
        end else begin
          e = sb.pop_front();
          check1("out_bit", out_bit, e.b);
          check1("out_sof", out_sof, e.sof);
          check1("out_eof", out_eof, e.eof);
          check1("out_err", out_err, e.err);
          if (e.eof) check1("out_corr", out_corr, e.corr);
        end
        in_frame = !out_eof;
      end else if (in_frame) begin
        checks++; errors++;
        $display("FAIL contiguity: out_valid dropped mid-frame at %0t", $time);
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    logic [N-1:0] cw;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_outputs", {out_valid, out_sof, out_eof, out_bit, out_err, out_corr}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_frame(0, 0, 0);              send_frame(15'b000000000000000, 0);
    push_frame(11'b00000000001, 0, 0); send_frame(15'b000000000010011, 0);
    push_frame(11'b10000000000, 0, 0); send_frame(15'b100000000001001, 0);
    push_frame(11'b10000000000, 1, 1); send_frame(15'b000000000001001, 0);

    for (int p = R; p < N; p++) begin
      cw = 15'b100000000001001;
      cw[p] = ~cw[p];
      push_frame(11'b10000000000, 1, 1);
      send_frame(cw, 0);
    end
    for (int p = 0; p < R; p++) begin
      cw = 15'b000000000010011;
      cw[p] = ~cw[p];
      push_frame(11'b00000000001, 1, 0);
      send_frame(cw, 0);
    end
    drain();

    repeat (3) random_frame(1, 0);
    random_frame(1, 3);
    drain();

    cw = N'(encode($urandom_range((1 << K) - 1, 0)));
    send_bits(cw, 7, 0);
    random_frame(1, 0);
    drain();

    repeat (25) random_frame(2, $urandom_range(2, 0));
    drain();

    random_frame(1, 0);
    repeat (5) @(posedge clk);
    #2;
    check1("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check1("async_reset_outputs", {out_valid, out_sof, out_eof, out_bit, out_err, out_corr}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    random_frame(1, 0);
    random_frame(0, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
